// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: serialises a 16-bit command word as two back-to-back 8N1
// UART frames (high byte first), then pulses cmd_sent for one cycle.
// The line output is taken straight from the low bit of a 10-bit frame
// shift register, so TX is always a flop output and idles high.
module uart_cmd_tx #(
   parameter int BAUD_CNT = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd_cmd,
   input  logic [15:0] cmd,
   output logic        TX,
   output logic        tx_busy,
   output logic        cmd_sent
);

   // Baud counter only has to reach BAUD_CNT-1; keep at least one bit so a
   // degenerate BAUD_CNT of 1 still elaborates.
   localparam int             BCW       = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_CNT - 1);
   localparam logic [3:0]     BIT_LAST  = 4'd9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      XMIT_HI = 2'd1,
      XMIT_LO = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;

   logic [15:0]    r_cmd;
   logic [9:0]     r_shift;
   logic [BCW-1:0] r_baud;
   logic [3:0]     r_bit;
   logic           r_tx_busy;
   logic           r_cmd_sent;

   logic           w_accept;
   logic           w_baud_last;
   logic           w_bit_end;
   logic           w_frame_end;
   logic           w_load_lo;
   logic           w_done;
   logic [15:0]    w_word;
   logic [7:0]     w_byte;

   assign w_baud_last = (r_baud == BAUD_LAST);

   // The word feeding the serializer: the live input on the accepting edge
   // (the holding register is only being written then), the held copy after.
   assign w_word = w_accept ? cmd : r_cmd;
   // A load from IDLE is always the high byte; any later load is the low byte.
   assign w_byte = (r_state == IDLE) ? w_word[15:8] : w_word[7:0];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: high frame, then low frame with no gap, then idle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = XMIT_HI;
            end
         end
         XMIT_HI: begin
            if (w_frame_end) begin
               w_state_nxt = XMIT_LO;
            end
         end
         XMIT_LO: begin
            if (w_frame_end) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Control strobes decoded from the state and the two counters.
   always_comb begin
      w_accept    = 1'b0;
      w_bit_end   = 1'b0;
      w_frame_end = 1'b0;
      w_load_lo   = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            // tx_busy is still high during the cmd_sent cycle, which keeps
            // a request arriving right then from being taken.
            w_accept = snd_cmd & ~r_tx_busy;
         end
         XMIT_HI: begin
            w_bit_end   = w_baud_last;
            w_frame_end = w_baud_last && (r_bit == BIT_LAST);
            w_load_lo   = w_frame_end;
         end
         XMIT_LO: begin
            w_bit_end   = w_baud_last;
            w_frame_end = w_baud_last && (r_bit == BIT_LAST);
            w_done      = w_frame_end;
         end
         default: begin
         end
      endcase
   end

   // Holding register: written only when a request is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd <= 16'h0000;
      end else if (w_accept) begin
         r_cmd <= cmd;
      end
   end

   // Baud counter: runs 0..BAUD_CNT-1 within each bit, cleared at every
   // bit boundary and held at zero while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud <= '0;
      end else if (r_state == IDLE || w_bit_end) begin
         r_baud <= '0;
      end else begin
         r_baud <= r_baud + BCW'(1);
      end
   end

   // Bit counter: 0 = start, 1..8 = data, 9 = stop; restarts per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit <= 4'd0;
      end else if (r_state == IDLE || w_frame_end) begin
         r_bit <= 4'd0;
      end else if (w_bit_end) begin
         r_bit <= r_bit + 4'd1;
      end
   end

   // Frame shift register: loads {stop, data, start} and shifts right with
   // ones entering at the top. After the tenth shift it is all ones again,
   // which is exactly the idle line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '1;
      end else if (w_accept || w_load_lo) begin
         r_shift <= {1'b1, w_byte, 1'b0};
      end else if (w_bit_end) begin
         r_shift <= {1'b1, r_shift[9:1]};
      end
   end

   // Busy flag: set on acceptance, dropped the cycle after cmd_sent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_busy <= 1'b0;
      end else if (w_accept) begin
         r_tx_busy <= 1'b1;
      end else if (r_cmd_sent) begin
         r_tx_busy <= 1'b0;
      end
   end

   // Completion pulse, coincident with the first cycle back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_sent <= 1'b0;
      end else begin
         r_cmd_sent <= w_done;
      end
   end

   assign TX       = r_shift[0];
   assign tx_busy  = r_tx_busy;
   assign cmd_sent = r_cmd_sent;

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: randomized bench for uart_cmd_tx. Expected line levels
// are computed from the frame layout with plain arithmetic (bit index =
// cycles / BAUD_CNT), and every word is also recovered by a mid-bit
// sampling receiver and compared with the word that was sent.
module tb_uart_cmd_tx;

   localparam int B        = 16;
   localparam int WORD_CYC = 20 * B;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snd_cmd;
   logic [15:0] cmd;
   logic        TX;
   logic        tx_busy;
   logic        cmd_sent;

   int n_vec = 0;
   int n_err = 0;

   // Transmission order for 16'h9A5C: high frame then low frame.
   int seq_9a5c [20] = '{0,0,1,0,1,1,0,0,1,1, 0,0,0,1,1,1,0,1,0,1};

   uart_cmd_tx #(.BAUD_CNT(B)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .snd_cmd  (snd_cmd),
      .cmd      (cmd),
      .TX       (TX),
      .tx_busy  (tx_busy),
      .cmd_sent (cmd_sent)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Line level n cycles after the accepting edge, for word w.
   function automatic logic model_tx(input logic [15:0] w, input int n);
      int         bitn;
      int         pos;
      logic [7:0] byte_v;
      bitn = n / B;
      if (bitn >= 20) return 1'b1;
      byte_v = (bitn < 10) ? w[15:8] : w[7:0];
      pos    = bitn % 10;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return byte_v[pos-1];
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_tx"},   32'(TX),       32'(1));
      check_eq({tag, "_busy"}, 32'(tx_busy),  32'(0));
      check_eq({tag, "_sent"}, 32'(cmd_sent), 32'(0));
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         snd_cmd = 1'b0;
         cmd     = 16'($urandom);
         check_idle("idle");
         @(negedge clk);
      end
   endtask

   // Called at a negedge with the DUT free: requests w, then checks every
   // cycle through the cmd_sent cycle. inj_n pulses snd_cmd with inj_cmd in
   // that cycle (must be ignored); abort_n asserts reset in that cycle.
   task automatic send_word(input logic [15:0] w, input int inj_n, input logic [15:0] inj_cmd,
                            input int abort_n, output logic [19:0] seq);
      logic [7:0] rx_hi;
      logic [7:0] rx_lo;
      logic [7:0] rx_cur;
      int         bitn;
      int         pos;
      bit         aborted;
      aborted = 1'b0;
      seq     = '1;
      rx_hi   = 8'h00;
      rx_lo   = 8'h00;
      rx_cur  = 8'h00;
      snd_cmd = 1'b1;
      cmd     = w;
      @(negedge clk);
      for (int n = 0; n <= WORD_CYC && !aborted; n++) begin
         check_eq("tx",   32'(TX),       32'(model_tx(w, n)));
         check_eq("busy", 32'(tx_busy),  32'(1));
         check_eq("sent", 32'(cmd_sent), 32'(n == WORD_CYC));
         if (n < WORD_CYC && (n % B) == B / 2) begin
            bitn       = n / B;
            pos        = bitn % 10;
            seq[bitn]  = TX;
            if (pos == 0) check_eq("start_bit", 32'(TX), 32'(0));
            if (pos >= 1 && pos <= 8) rx_cur[pos-1] = TX;
            if (pos == 9) begin
               check_eq("stop_bit", 32'(TX), 32'(1));
               if (bitn < 10) rx_hi = rx_cur;
               else           rx_lo = rx_cur;
            end
         end
         if (n == abort_n) begin
            rst_n   = 1'b0;
            snd_cmd = 1'b0;
            #1;
            check_idle("abort");
            for (int i = 0; i < 2; i++) begin
               @(negedge clk);
               check_idle("in_rst");
            end
            rst_n = 1'b1;
            @(negedge clk);
            check_idle("rst_rel");
            aborted = 1'b1;
         end else begin
            snd_cmd = (n == inj_n);
            cmd     = (n == inj_n) ? inj_cmd : 16'($urandom);
            @(negedge clk);
         end
      end
      if (!aborted) check_eq("rx_word", 32'({rx_hi, rx_lo}), 32'(w));
   endtask

   initial begin
      logic [19:0] seq;
      logic [19:0] seq_exp;

      rst_n   = 1'b0;
      snd_cmd = 1'b0;
      cmd     = 16'h0000;
      @(negedge clk);
      check_idle("reset");
      snd_cmd = 1'b1;
      cmd     = 16'hFFFF;
      @(negedge clk);
      check_idle("reset_req");
      snd_cmd = 1'b0;
      rst_n   = 1'b1;
      idle_cycles(3);

      // Directed word, with a stray request at bit 5 of the high frame.
      send_word(16'h9A5C, 5 * B + 3, 16'hFFFF, -1, seq);
      for (int i = 0; i < 20; i++) seq_exp[i] = (seq_9a5c[i] != 0);
      check_eq("seq_9A5C", 32'(seq), 32'(seq_exp));
      idle_cycles(2);

      // Request in the cmd_sent cycle is dropped; one cycle later is taken.
      send_word(16'($urandom), WORD_CYC, 16'($urandom), -1, seq);
      send_word(16'($urandom), -1, 16'h0000, -1, seq);
      idle_cycles(1);

      // Reset during bit 3 of the low frame, then a clean 16'h0001.
      send_word(16'($urandom), -1, 16'h0000, 13 * B + int'($urandom_range(0, B - 1)), seq);
      idle_cycles(2);
      send_word(16'h0001, -1, 16'h0000, -1, seq);
      idle_cycles(1);

      // Random words, stray requests, back-to-back sends and aborts.
      for (int k = 0; k < 10; k++) begin
         int sel;
         int inj;
         int ab;
         int gap;
         sel = int'($urandom_range(0, 3));
         if (sel == 0)      inj = -1;
         else if (sel == 1) inj = WORD_CYC;
         else               inj = int'($urandom_range(0, WORD_CYC - 1));
         ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, WORD_CYC - 1)) : -1;
         send_word(16'($urandom), inj, 16'($urandom), ab, seq);
         gap = (inj == WORD_CYC && ab < 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
         idle_cycles(gap);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
